// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
// Divide-by-zero bypasses the iteration and reports all-ones / dividend.
module seq_divider #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);

    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e         r_state;
    state_e         w_state_next;
    logic [N-1:0]   r_dvd;
    logic [N-1:0]   r_divisor;
    logic [N-1:0]   r_rem;
    logic [CW-1:0]  r_count;
    logic [N-1:0]   r_quotient;
    logic [N-1:0]   r_remainder;
    logic           r_dbz;

    logic           w_accept;
    logic           w_last;
    logic [N:0]     w_shift;
    logic [N:0]     w_diff;
    logic           w_ge;
    logic [N-1:0]   w_rem_next;

    assign w_accept = start && (r_state != StCalc);
    assign w_last   = (r_state == StCalc) && (r_count == CW'(1));

    // Partial remainder is always below the divisor, so bit N of the
    // difference is a clean borrow flag.
    assign w_shift    = {r_rem, r_dvd[N-1]};
    assign w_diff     = w_shift - {1'b0, r_divisor};
    assign w_ge       = ~w_diff[N];
    assign w_rem_next = w_ge ? w_diff[N-1:0] : w_shift[N-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle, StDone: begin
                if (start) begin
                    w_state_next = (divisor == '0) ? StDone : StCalc;
                end else begin
                    w_state_next = StIdle;
                end
            end
            StCalc: begin
                if (w_last) begin
                    w_state_next = StDone;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        busy = (r_state == StCalc);
        done = (r_state == StDone);
    end

    // Dividend register doubles as the quotient shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dvd       <= '0;
            r_divisor   <= '0;
            r_rem       <= '0;
            r_count     <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else if (w_accept) begin
            r_dvd     <= dividend;
            r_divisor <= divisor;
            r_rem     <= '0;
            r_count   <= CW'(N);
            if (divisor == '0) begin
                r_quotient  <= '1;
                r_remainder <= dividend;
                r_dbz       <= 1'b1;
            end else begin
                r_dbz <= 1'b0;
            end
        end else if (r_state == StCalc) begin
            r_rem   <= w_rem_next;
            r_dvd   <= {r_dvd[N-2:0], w_ge};
            r_count <= r_count - CW'(1);
            if (w_last) begin
                r_quotient  <= {r_dvd[N-2:0], w_ge};
                r_remainder <= w_rem_next;
            end
        end
    end

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Randomized bench for seq_divider against an arithmetic (/, %) reference
// with cycle-exact expectations for busy, done and held results.
module tb_seq_divider;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    int n_vec = 0;
    int n_err = 0;

    logic [N-1:0] exp_q;
    logic [N-1:0] exp_r;
    logic         exp_dbz;

    seq_divider #(.N(N)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_results(input string tag);
        check_eq({tag, ".quotient"}, 32'(quotient), 32'(exp_q));
        check_eq({tag, ".remainder"}, 32'(remainder), 32'(exp_r));
        check_eq({tag, ".dbz"}, 32'(div_by_zero), 32'(exp_dbz));
    endtask

    // Issue one division; on return the bench sits in the DONE cycle.
    task automatic run_op(input int a, input int b, input bit mid_start);
        dividend = N'(a);
        divisor  = N'(b);
        start    = 1'b1;
        tick();
        start    = 1'b0;
        dividend = N'($urandom);
        divisor  = N'($urandom);
        if (b != 0) begin
            exp_dbz = 1'b0;
            for (int k = 0; k < N; k++) begin
                check_eq("calc.busy", 32'(busy), 32'd1);
                check_eq("calc.done", 32'(done), 32'd0);
                check_results("calc.hold");
                start    = (mid_start && k == 2);
                dividend = N'($urandom);
                divisor  = N'($urandom);
                tick();
            end
            start = 1'b0;
            exp_q = N'(a / b);
            exp_r = N'(a % b);
        end else begin
            exp_q   = '1;
            exp_r   = N'(a);
            exp_dbz = 1'b1;
        end
        check_eq("done.done", 32'(done), 32'd1);
        check_eq("done.busy", 32'(busy), 32'd0);
        check_results("done");
    endtask

    task automatic idle_check();
        tick();
        check_eq("idle.done", 32'(done), 32'd0);
        check_eq("idle.busy", 32'(busy), 32'd0);
        check_results("idle.hold");
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b1;
        dividend = 8'd77;
        divisor  = 8'd3;
        tick();
        tick();
        exp_q = '0; exp_r = '0; exp_dbz = 1'b0;
        check_eq("rst.busy", 32'(busy), 32'd0);
        check_eq("rst.done", 32'(done), 32'd0);
        check_results("rst");

        rst = 1'b0;
        run_op(100, 7, 1'b0);
        idle_check();
        run_op(255, 1, 1'b0);
        idle_check();
        run_op(3, 10, 1'b0);
        idle_check();
        run_op(5, 0, 1'b0);
        idle_check();

        // Start during CALC is ignored; start in DONE chains.
        run_op(200, 9, 1'b1);
        run_op(50, 5, 1'b0);
        idle_check();

        // Abort mid-calculation.
        dividend = 8'd123;
        divisor  = 8'd4;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q = '0; exp_r = '0; exp_dbz = 1'b0;
        check_eq("abort.busy", 32'(busy), 32'd0);
        check_eq("abort.done", 32'(done), 32'd0);
        check_results("abort");
        for (int k = 0; k < N + 2; k++) begin
            tick();
            check_eq("abort.nodone", 32'(done), 32'd0);
        end
        run_op(9, 3, 1'b0);
        idle_check();

        for (int i = 0; i < 60; i++) begin
            int a;
            int b;
            a = int'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
            run_op(a, b, $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 1) == 1) idle_check();
        end
        idle_check();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have one parameter: N, default 8, meaning operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request a division, sampled on a clk edge.
REQ-005 The block SHALL have port dividend, input, N bits: unsigned dividend, sampled with start.
REQ-006 The block SHALL have port divisor, input, N bits: unsigned divisor, sampled with start.
REQ-007 The block SHALL have port quotient, output, N bits: registered unsigned quotient.
REQ-008 The block SHALL have port remainder, output, N bits: registered unsigned remainder.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse when results are valid.
REQ-011 The block SHALL have port div_by_zero, output, 1 bit: high with done when divisor was 0.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-013 In IDLE or DONE, start=1 at a clk edge SHALL latch dividend and divisor internally, load the step counter with N, and enter CALC (divisor!=0) or DONE (divisor==0).
REQ-014 Operand inputs SHALL be ignored at every edge except the edge that accepts start.
REQ-015 In CALC, each edge SHALL perform one restoring step: shift the partial remainder left by 1, shift in the next dividend bit (MSB first), trial-subtract the divisor at N+1 bits, keep the difference and set the quotient bit to 1 if it is non-negative, else restore and set the quotient bit to 0.
REQ-016 After the Nth CALC step, the FSM SHALL enter DONE with quotient and remainder registered; for divisor!=0, done SHALL be high in the cycle following edge E0+N, where E0 is the accepting edge.
REQ-017 Division by zero SHALL bypass CALC: done=1, div_by_zero=1, quotient=all ones, remainder=dividend, all valid in the cycle after E0.
REQ-018 done SHALL be high for exactly one cycle (DONE state); without a new start, DONE SHALL return to IDLE on the next edge.
REQ-019 busy SHALL be 1 exactly while in CALC, and 0 in IDLE and DONE.
REQ-020 start while in CALC SHALL be ignored, with no effect on the current operation or results.
REQ-021 start in DONE SHALL be accepted per REQ-013, allowing back-to-back operations.
REQ-022 quotient, remainder and div_by_zero SHALL hold their values from DONE until the next completed operation; while in CALC they SHALL keep their previous values.
REQ-023 div_by_zero SHALL be cleared when a new non-zero-divisor operation is accepted.
REQ-024 Results SHALL satisfy dividend = quotient*divisor + remainder, with remainder < divisor, for all divisor!=0.

Reset
REQ-025 rst=1 at a clk edge SHALL force the FSM to IDLE, clear quotient, remainder, busy, done and div_by_zero to 0, and clear internal registers.
REQ-026 rst SHALL take priority over start and SHALL abort any operation in progress with no done pulse.
REQ-027 The first start SHALL be accepted at the first edge with rst=0.

Verification
REQ-028 N=8: dividend=100, divisor=7, start pulse -> busy for 8 cycles, then done=1 for 1 cycle with quotient=14, remainder=2, div_by_zero=0.
REQ-029 dividend=255, divisor=1 -> quotient=255, remainder=0; then dividend=3, divisor=10 -> quotient=0, remainder=3.
REQ-030 dividend=5, divisor=0 -> done 1 cycle after start, with div_by_zero=1, quotient=0xFF, remainder=5, and busy never 1.
REQ-031 Start 200/9, pulse start with 50/5 during CALC -> result quotient=22, remainder=2 and only one done pulse; start 50/5 in the DONE cycle -> next result quotient=10, remainder=0.
REQ-032 Assert rst at the 4th CALC cycle -> next cycle all outputs 0 and FSM in IDLE, no done pulse; a following 9/3 start yields quotient=3, remainder=0.
